modexp_arbiter: RTL and testbench
=================================

MODEXP_ARBITER -- requirements
Module: modexp_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024: max WAIT-state cycles before abort.
REQ-002 clk  in  1  rising-edge clock, single clock domain.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0, req1  in  1 each  level request from requester 0/1.
REQ-005 base0, base1  in  4 each  exponentiation base.
REQ-006 exp0, exp1  in  32 each  exponent.
REQ-007 mod0, mod1  in  32 each  modulus.
REQ-008 eng_start  out  1  one-cycle start pulse to the shared modexp engine.
REQ-009 eng_base / eng_exp / eng_mod  out  4 / 32 / 32  latched operands to the engine.
REQ-010 eng_done  in  1  engine completion pulse; eng_result  in  4  engine result, valid with eng_done.
REQ-011 gnt  out  2  one-hot grant, bit k = requester k owns the engine.
REQ-012 done0, done1  out  1 each  one-cycle completion pulse per requester.
REQ-013 res0, res1  out  4 each  result, valid while matching done pulse is high, held afterwards.
REQ-014 err  out  1  one-cycle pulse with done_k: modulus zero or timeout.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states IDLE, START, WAIT, RESP; all outputs registered.
REQ-017 IDLE: no req -> stay; any req -> select winner, latch base/exp/mod of winner into eng_* and set gnt, go START.
REQ-018 Arbitration round-robin: both req high -> winner is requester not served last; single req -> that requester; last-served pointer resets to 1 (so requester 0 wins first tie).
REQ-019 Latched mod == 0 -> skip engine: go from IDLE directly to RESP with err=1, res=0; eng_start never asserted.
REQ-020 START: eng_start=1 exactly one cycle, counter cleared, go WAIT.
REQ-021 WAIT: eng_done sampled only in WAIT; on eng_done capture eng_result, go RESP, err=0.
REQ-022 WAIT: counter increments per cycle; counter == TIMEOUT_CYC-1 with no eng_done -> go RESP, res=0, err=1; eng_done in same cycle as timeout wins (normal result).
REQ-023 RESP: done_k=1 and res_k driven for granted k for one cycle; last-served pointer updated to k; gnt cleared; go IDLE.
REQ-024 Latency: req sampled in IDLE at cycle T -> eng_start at T+1; eng_done at cycle D -> done_k at D+1.
REQ-025 req drop after grant ignored: operation completes and done_k still pulses.
REQ-026 req held high through done treated as new request in following IDLE cycle, subject to round-robin.
REQ-027 eng_done outside WAIT ignored; eng_* operands stable from START until leaving WAIT.
REQ-028 Non-granted requester's done/res unchanged throughout.

Reset
REQ-029 rst high at a clock edge -> state IDLE, gnt=0, eng_start=0, eng_base/eng_exp/eng_mod=0, done0=done1=0, res0=res1=0, err=0, busy=0, counter=0, last-served=1.
REQ-030 rst mid-operation (START/WAIT/RESP) aborts without done pulse; a later eng_done from the aborted job is ignored.

Verification
REQ-031 req0=1, base0=3, exp0=4, mod0=7; engine returns 4 after 5 cycles -> one eng_start with 3/4/7, done0 pulse with res0=4, err=0, done1 never asserted.
REQ-032 req0=req1=1 held continuously, engine 2-cycle latency -> grants alternate 0,1,0,1; each done_k one cycle; no starvation.
REQ-033 req1=1, mod1=0 -> no eng_start, done1 and err pulse same cycle, res1=0, return to IDLE 1 cycle later.
REQ-034 TIMEOUT_CYC=8, engine never responds -> done0 with err=1, res0=0 exactly 8 WAIT cycles after START; late eng_done ignored.
REQ-035 rst asserted during WAIT, then eng_done pulse -> all outputs at reset values, no done pulse; next req0 served normally.
REQ-036 req0 pulsed one cycle then dropped -> job runs to completion, done0 asserted once.

Source files
------------

// File: rtl/modexp_arbiter_if.sv
// Bundle of requester, engine and status signals between the modexp arbiter
// and the two requesters plus the shared exponentiation engine.
interface modexp_arbiter_if;
    logic        req0;
    logic        req1;
    logic [3:0]  base0;
    logic [3:0]  base1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] mod0;
    logic [31:0] mod1;

    logic        eng_start;
    logic [3:0]  eng_base;
    logic [31:0] eng_exp;
    logic [31:0] eng_mod;
    logic        eng_done;
    logic [3:0]  eng_result;

    logic [1:0]  gnt;
    logic        done0;
    logic        done1;
    logic [3:0]  res0;
    logic [3:0]  res1;
    logic        err;
    logic        busy;

    // master: requesters and engine side; slave: the arbiter
    modport master (
        output req0, req1, base0, base1, exp0, exp1, mod0, mod1,
        output eng_done, eng_result,
        input  eng_start, eng_base, eng_exp, eng_mod,
        input  gnt, done0, done1, res0, res1, err, busy
    );

    modport slave (
        input  req0, req1, base0, base1, exp0, exp1, mod0, mod1,
        input  eng_done, eng_result,
        output eng_start, eng_base, eng_exp, eng_mod,
        output gnt, done0, done1, res0, res1, err, busy
    );
endinterface

// File: rtl/modexp_arbiter.sv
// Round-robin arbiter sharing one modexp engine between two requesters,
// with zero-modulus bypass and a WAIT-state timeout.
//
// state   | meaning
// S_IDLE  | no job; pick a winner when any request is high
// S_START | eng_start pulse out, timeout counter cleared
// S_WAIT  | waiting for eng_done or timeout
// S_RESP  | done/res/err presented to the granted requester for one cycle
module modexp_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic            clk,
    input  logic            rst,
    modexp_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             start_q, start_d;
    logic [3:0]       base_q, base_d;
    logic [31:0]      exp_q, exp_d;
    logic [31:0]      mod_q, mod_d;
    logic [1:0]       done_q, done_d;
    logic [3:0]       res0_q, res0_d;
    logic [3:0]       res1_q, res1_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    logic             win;
    logic [31:0]      win_mod;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        start_d = 1'b0;
        base_d  = base_q;
        exp_d   = exp_q;
        mod_d   = mod_q;
        done_d  = 2'b00;
        res0_d  = res0_q;
        res1_d  = res1_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        last_d  = last_q;

        // on a tie the requester not served last wins
        win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        win_mod = win ? bus.mod1 : bus.mod0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt_d  = win ? 2'b10 : 2'b01;
                    base_d = win ? bus.base1 : bus.base0;
                    exp_d  = win ? bus.exp1 : bus.exp0;
                    mod_d  = win_mod;
                    if (win_mod == 32'd0) begin
                        // engine bypass: answer immediately with an error
                        state_d = S_RESP;
                        done_d  = gnt_d;
                        err_d   = 1'b1;
                        if (win) begin
                            res1_d = 4'd0;
                        end else begin
                            res0_d = 4'd0;
                        end
                    end else begin
                        state_d = S_START;
                        start_d = 1'b1;
                    end
                end
            end

            S_START: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end

            S_WAIT: begin
                if (bus.eng_done) begin
                    // a completion on the timeout cycle still counts as success
                    state_d = S_RESP;
                    done_d  = gnt_q;
                    if (gnt_q[1]) begin
                        res1_d = bus.eng_result;
                    end else begin
                        res0_d = bus.eng_result;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    if (gnt_q[1]) begin
                        res1_d = 4'd0;
                    end else begin
                        res0_d = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                last_d  = gnt_q[1];
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            start_q <= 1'b0;
            base_q  <= 4'd0;
            exp_q   <= 32'd0;
            mod_q   <= 32'd0;
            done_q  <= 2'b00;
            res0_q  <= 4'd0;
            res1_q  <= 4'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            mod_q   <= mod_d;
            done_q  <= done_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign bus.eng_start = start_q;
    assign bus.eng_base  = base_q;
    assign bus.eng_exp   = exp_q;
    assign bus.eng_mod   = mod_q;
    assign bus.gnt       = gnt_q;
    assign bus.done0     = done_q[0];
    assign bus.done1     = done_q[1];
    assign bus.res0      = res0_q;
    assign bus.res1      = res1_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_modexp_arbiter.sv
// Bench for modexp_arbiter: job-timeline reference model checked every cycle,
// a behavioural modexp engine, and directed scenarios with literal expectations.
module tb_modexp_arbiter;

    localparam int TO = 8;

    logic clk;
    logic rst;
    modexp_arbiter_if bus ();

    modexp_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, expv);
        end
    endtask

    // reference modexp, used by the engine stand-in
    function automatic logic [3:0] modpow(input logic [3:0] b, input logic [31:0] e, input logic [31:0] m);
        logic [63:0] r, x, mm;
        if (m == 32'd0) return 4'd0;
        mm = {32'd0, m};
        r  = 64'd1 % mm;
        x  = {60'd0, b} % mm;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[3:0];
    endfunction

    // engine stand-in: answers eng_start after eng_lat cycles
    int eng_lat  = 2;
    bit eng_busy = 1'b0;
    initial begin
        logic [3:0] lr;
        bus.eng_done   = 1'b0;
        bus.eng_result = 4'd0;
        forever begin
            @(negedge clk);
            if (bus.eng_start === 1'b1 && !eng_busy) begin
                eng_busy = 1'b1;
                lr = modpow(bus.eng_base, bus.eng_exp, bus.eng_mod);
                repeat (eng_lat) @(negedge clk);
                bus.eng_result = lr;
                bus.eng_done   = 1'b1;
                @(negedge clk);
                bus.eng_done   = 1'b0;
                bus.eng_result = 4'd0;
                eng_busy       = 1'b0;
            end
        end
    end

    // Model: a job granted at edge e0 starts the engine right after e0,
    // accepts eng_done on edges e0+2 .. e0+1+TO, answers after the resolving
    // edge and frees the arbiter one edge later.
    bit          mvalid = 1'b0;
    bit          j_act  = 1'b0;
    bit          j_own;
    bit          j_err;
    int          j_e0;
    int          j_resp;
    bit          last_srv = 1'b1;
    logic [3:0]  x_base, x_res0, x_res1;
    logic [31:0] x_exp, x_mod;
    logic [1:0]  x_gnt;
    logic        x_start, x_busy, x_err, x_done0, x_done1;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mvalid   = 1'b1;
                j_act    = 1'b0;
                last_srv = 1'b1;
                x_base   = 4'd0;
                x_exp    = 32'd0;
                x_mod    = 32'd0;
                x_res0   = 4'd0;
                x_res1   = 4'd0;
            end else if (!j_act) begin
                if (bus.req0 || bus.req1) begin
                    j_own  = (bus.req0 && bus.req1) ? !last_srv : bus.req1;
                    j_act  = 1'b1;
                    j_e0   = cyc;
                    x_base = j_own ? bus.base1 : bus.base0;
                    x_exp  = j_own ? bus.exp1 : bus.exp0;
                    x_mod  = j_own ? bus.mod1 : bus.mod0;
                    j_resp = -1;
                    if (x_mod == 32'd0) begin
                        j_resp = cyc;
                        j_err  = 1'b1;
                        if (j_own) x_res1 = 4'd0; else x_res0 = 4'd0;
                    end
                end
            end else if (j_resp < 0) begin
                if (cyc >= j_e0 + 2 && bus.eng_done) begin
                    j_resp = cyc;
                    j_err  = 1'b0;
                    if (j_own) x_res1 = bus.eng_result; else x_res0 = bus.eng_result;
                end else if (cyc == j_e0 + 1 + TO) begin
                    j_resp = cyc;
                    j_err  = 1'b1;
                    if (j_own) x_res1 = 4'd0; else x_res0 = 4'd0;
                end
            end else if (cyc == j_resp + 1) begin
                j_act    = 1'b0;
                last_srv = j_own;
            end
            x_gnt   = j_act ? (j_own ? 2'b10 : 2'b01) : 2'b00;
            x_busy  = j_act;
            x_start = j_act && (x_mod != 32'd0) && (cyc == j_e0);
            x_done0 = j_act && (j_resp == cyc) && !j_own;
            x_done1 = j_act && (j_resp == cyc) && j_own;
            x_err   = j_act && (j_resp == cyc) && j_err;
        end
    end

    // per-cycle compare plus event monitor
    int         n_start = 0, n_done0 = 0, n_done1 = 0;
    int         st_cyc, dn0_cyc, dn1_cyc;
    logic [3:0] st_base, dn0_res, dn1_res;
    logic [31:0] st_exp, st_mod;
    logic       dn0_err, dn1_err;
    int         own_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                chk("gnt",       64'(bus.gnt),       64'(x_gnt));
                chk("eng_start", 64'(bus.eng_start), 64'(x_start));
                chk("busy",      64'(bus.busy),      64'(x_busy));
                chk("done0",     64'(bus.done0),     64'(x_done0));
                chk("done1",     64'(bus.done1),     64'(x_done1));
                chk("err",       64'(bus.err),       64'(x_err));
                chk("res0",      64'(bus.res0),      64'(x_res0));
                chk("res1",      64'(bus.res1),      64'(x_res1));
                chk("eng_base",  64'(bus.eng_base),  64'(x_base));
                chk("eng_exp",   64'(bus.eng_exp),   64'(x_exp));
                chk("eng_mod",   64'(bus.eng_mod),   64'(x_mod));
            end
            if (bus.eng_start === 1'b1) begin
                n_start++;
                st_cyc  = cyc;
                st_base = bus.eng_base;
                st_exp  = bus.eng_exp;
                st_mod  = bus.eng_mod;
            end
            if (bus.done0 === 1'b1) begin
                n_done0++;
                dn0_cyc = cyc;
                dn0_res = bus.res0;
                dn0_err = bus.err;
                own_q.push_back(0);
            end
            if (bus.done1 === 1'b1) begin
                n_done1++;
                dn1_cyc = cyc;
                dn1_res = bus.res1;
                dn1_err = bus.err;
                own_q.push_back(1);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int cnt_of(input int k);
        case (k)
            0:       return n_done0;
            1:       return n_done1;
            default: return n_start;
        endcase
    endfunction

    task automatic wait_evt(input int k, input int budget, input string tag);
        int b = cnt_of(k);
        int n = 0;
        while (cnt_of(k) == b && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < budget), 64'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        tick();
        while ((j_act || eng_busy) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < budget), 64'd1);
    endtask

    initial begin
        int s0, d0, d1, rc;
        rst = 1'b1;
        bus.req0 = 1'b0;  bus.req1 = 1'b0;
        bus.base0 = 4'd0; bus.base1 = 4'd0;
        bus.exp0 = 32'd0; bus.exp1 = 32'd0;
        bus.mod0 = 32'd0; bus.mod1 = 32'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // model pins: reference values the scenarios rely on
        chk("pin_pow_3_4_7", 64'(modpow(4'd3, 32'd4, 32'd7)), 64'd4);
        chk("pin_pow_5_3_11", 64'(modpow(4'd5, 32'd3, 32'd11)), 64'd4);

        // both requesters held: grants alternate starting with requester 0
        own_q.delete();
        eng_lat = 2;
        bus.base0 = 4'd2; bus.exp0 = 32'd5; bus.mod0 = 32'd13;
        bus.base1 = 4'd5; bus.exp1 = 32'd3; bus.mod1 = 32'd11;
        bus.req0 = 1'b1;  bus.req1 = 1'b1;
        rc = 0;
        while (own_q.size() < 4 && rc < 200) begin
            tick();
            rc++;
        end
        bus.req0 = 1'b0;  bus.req1 = 1'b0;
        chk("rr_four_dones", 64'(rc < 200), 64'd1);
        for (int i = 0; i < 4; i++)
            chk("rr_owner", 64'((i < own_q.size()) ? own_q[i] : 99), 64'(i % 2));
        chk("rr_res0", 64'(dn0_res), 64'd6);
        chk("rr_res1", 64'(dn1_res), 64'd4);
        wait_idle(100, "rr_idle");

        // single requester 0: 3^4 mod 7 with a 5-cycle engine
        s0 = n_start; d1 = n_done1;
        eng_lat = 5;
        bus.base0 = 4'd3; bus.exp0 = 32'd4; bus.mod0 = 32'd7;
        bus.req0 = 1'b1;
        wait_evt(0, 50, "basic_done_seen");
        bus.req0 = 1'b0;
        wait_idle(50, "basic_idle");
        chk("basic_starts", 64'(n_start - s0), 64'd1);
        chk("basic_base", 64'(st_base), 64'd3);
        chk("basic_exp", 64'(st_exp), 64'd4);
        chk("basic_mod", 64'(st_mod), 64'd7);
        chk("basic_res0", 64'(dn0_res), 64'd4);
        chk("basic_err", 64'(dn0_err), 64'd0);
        chk("basic_latency", 64'(dn0_cyc - st_cyc), 64'd6);
        chk("basic_no_done1", 64'(n_done1 - d1), 64'd0);

        // zero modulus on requester 1: bypass the engine
        s0 = n_start; d1 = n_done1;
        bus.base1 = 4'd9; bus.exp1 = 32'd2; bus.mod1 = 32'd0;
        bus.req1 = 1'b1;
        rc = cyc;
        wait_evt(1, 20, "mod0_done_seen");
        bus.req1 = 1'b0;
        wait_idle(20, "mod0_idle");
        chk("mod0_starts", 64'(n_start - s0), 64'd0);
        chk("mod0_done1", 64'(n_done1 - d1), 64'd1);
        chk("mod0_err", 64'(dn1_err), 64'd1);
        chk("mod0_res1", 64'(dn1_res), 64'd0);
        chk("mod0_latency", 64'(dn1_cyc - rc), 64'd1);

        // engine slower than the timeout: error after 8 WAIT cycles, late done ignored
        d0 = n_done0; d1 = n_done1;
        eng_lat = 12;
        bus.base0 = 4'd2; bus.exp0 = 32'd3; bus.mod0 = 32'd5;
        bus.req0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        wait_evt(0, 50, "to_done_seen");
        chk("to_err", 64'(dn0_err), 64'd1);
        chk("to_res0", 64'(dn0_res), 64'd0);
        chk("to_latency", 64'(dn0_cyc - st_cyc), 64'd9);
        wait_idle(50, "to_idle");
        repeat (3) tick();
        chk("to_single_done", 64'(n_done0 - d0), 64'd1);
        chk("to_no_done1", 64'(n_done1 - d1), 64'd0);

        // eng_done on the very timeout edge wins: 2^4 mod 7 = 2
        eng_lat = 8;
        bus.base1 = 4'd2; bus.exp1 = 32'd4; bus.mod1 = 32'd7;
        bus.req1 = 1'b1;
        tick();
        bus.req1 = 1'b0;
        wait_evt(1, 50, "edge_done_seen");
        chk("edge_err", 64'(dn1_err), 64'd0);
        chk("edge_res1", 64'(dn1_res), 64'd2);
        wait_idle(50, "edge_idle");

        // reset during WAIT, stray eng_done afterwards, then a normal job
        d0 = n_done0;
        eng_lat = 6;
        bus.base0 = 4'd3; bus.exp0 = 32'd3; bus.mod0 = 32'd10;
        bus.req0 = 1'b1;
        wait_evt(2, 20, "abort_start_seen");
        bus.req0 = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_gnt", 64'(bus.gnt), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_eng_mod", 64'(bus.eng_mod), 64'd0);
        wait_idle(50, "abort_idle");
        repeat (3) tick();
        chk("abort_no_done", 64'(n_done0 - d0), 64'd0);
        eng_lat = 2;
        bus.req0 = 1'b1;
        wait_evt(0, 50, "after_abort_done_seen");
        bus.req0 = 1'b0;
        chk("after_abort_res0", 64'(dn0_res), 64'd7);
        chk("after_abort_err", 64'(dn0_err), 64'd0);
        wait_idle(50, "after_abort_idle");

        // one-cycle request pulse still completes exactly once: 4^2 mod 11 = 5
        d0 = n_done0;
        bus.base0 = 4'd4; bus.exp0 = 32'd2; bus.mod0 = 32'd11;
        bus.req0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        wait_idle(50, "pulse_idle");
        repeat (3) tick();
        chk("pulse_done_once", 64'(n_done0 - d0), 64'd1);
        chk("pulse_res0", 64'(dn0_res), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
